// File: rtl/packer_feeder_pkg.sv
// Shared constants and width helpers for packer_feeder and the packer that consumes it.
package packer_feeder_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 16;
    localparam int unsigned STALL_CNT_W        = 16;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Address width for a buffer of 'depth' entries; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/feeder_fifo_mem.sv
// Register-array storage for packer_feeder: one synchronous write port, one combinational read port.
module feeder_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data_c
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/packer_feeder.sv
// packer_feeder: byte-stream FIFO feeding the packer's ReqDat/ValDat handshake.
// Each ReqDat seen while data is buffered yields ValDat one clock later.
// Optional: define PACKER_FEEDER_STALL_CNT_EN to add the saturating StallCnt output.
module packer_feeder
    import packer_feeder_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int unsigned DEPTH      = DEFAULT_DEPTH,
    localparam int unsigned PTR_W      = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Flush,
    input  logic                  InVld,
    output logic                  InRdy,
    input  logic [DATA_WIDTH-1:0] InDat,
    input  logic                  ReqDat,
    output logic                  ValDat,
    output logic [DATA_WIDTH-1:0] Dat,
    output logic [PTR_W:0]        Level,
    output logic                  Empty,
    output logic                  Full
`ifdef PACKER_FEEDER_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] StallCnt
`endif
);

    localparam int unsigned PTR_LEN = PTR_W + 1;

    logic [PTR_W:0]        wr_ptr;
    logic [PTR_W:0]        rd_ptr;
    logic                  empty_c;
    logic                  full_c;
    logic                  push_c;
    logic                  pop_c;
    logic [DATA_WIDTH-1:0] rd_data_c;

    // Occupancy flags decoded from the wrap-bit pointers.
    always_comb begin
        empty_c = (wr_ptr == rd_ptr);
        full_c  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    end

    // Flush wins over both ports; a full FIFO refuses pushes even if a pop frees a slot this cycle.
    always_comb begin
        push_c = InVld && !full_c && !Flush;
        pop_c  = ReqDat && !empty_c && !Flush;
    end

    assign InRdy = !full_c;
    assign Empty = empty_c;
    assign Full  = full_c;
    assign Level = wr_ptr - rd_ptr;

    feeder_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk       (clk),
        .wr_en     (push_c),
        .wr_addr   (wr_ptr[PTR_W-1:0]),
        .wr_data   (InDat),
        .rd_addr   (rd_ptr[PTR_W-1:0]),
        .rd_data_c (rd_data_c)
    );

    // Read/write pointer update; flush returns both to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_LEN'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_LEN'(1);
            end
        end
    end

    // Output register: ValDat follows an accepted request by one clock; Dat holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValDat <= 1'b0;
            Dat    <= '0;
        end else begin
            ValDat <= pop_c;
            if (pop_c) begin
                Dat <= rd_data_c;
            end
        end
    end

`ifdef PACKER_FEEDER_STALL_CNT_EN
    // Saturating count of cycles where the packer asked while nothing was buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCnt <= '0;
        end else if (Flush) begin
            StallCnt <= '0;
        end else if (ReqDat && empty_c && (StallCnt != {STALL_CNT_W{1'b1}})) begin
            StallCnt <= StallCnt + STALL_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_packer_feeder.sv
// Scoreboard bench for packer_feeder: a queue-based model predicts each delivered word,
// a monitor compares every cycle's outputs against that prediction.
module tb_packer_feeder;
    import packer_feeder_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PW    = 4;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          Flush  = 1'b0;
    logic          InVld  = 1'b0;
    logic [DW-1:0] InDat  = '0;
    logic          ReqDat = 1'b0;
    logic          InRdy;
    logic          ValDat;
    logic [DW-1:0] Dat;
    logic [PW:0]   Level;
    logic          Empty;
    logic          Full;
`ifdef PACKER_FEEDER_STALL_CNT_EN
    logic [15:0]   StallCnt;
`endif

    packer_feeder #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Flush    (Flush),
        .InVld    (InVld),
        .InRdy    (InRdy),
        .InDat    (InDat),
        .ReqDat   (ReqDat),
        .ValDat   (ValDat),
        .Dat      (Dat),
        .Level    (Level),
        .Empty    (Empty),
        .Full     (Full)
`ifdef PACKER_FEEDER_STALL_CNT_EN
        ,
        .StallCnt (StallCnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: buffered words, words owed to the packer, and registered-output view.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    logic          m_val   = 1'b0;
    logic [DW-1:0] m_dat   = '0;
    logic [15:0]   m_stall = '0;
    int            m_sz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a bounded queue; a request takes the oldest word present before this edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            exp_q.delete();
            m_val   = 1'b0;
            m_dat   = '0;
            m_stall = '0;
        end else if (Flush) begin
            model_q.delete();
            m_val   = 1'b0;
            m_stall = '0;
        end else begin
            m_sz = model_q.size();
            if (ReqDat && m_sz == 0 && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (ReqDat && m_sz > 0) begin
                m_dat = model_q.pop_front();
                exp_q.push_back(m_dat);
                m_val = 1'b1;
            end else begin
                m_val = 1'b0;
            end
            if (InVld && m_sz < int'(DEPTH)) model_q.push_back(InDat);
        end
    end

    // Monitor: compares registered outputs mid-cycle; delivered words come off the expected queue.
    always @(negedge clk) begin
        chk("ValDat", 32'(ValDat), 32'(m_val));
        if (ValDat === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL Dat_unexpected: got %0h expected no word at %0t", Dat, $time);
            end else begin
                chk("Dat", 32'(Dat), 32'(exp_q.pop_front()));
            end
        end else begin
            chk("Dat_hold", 32'(Dat), 32'(m_dat));
        end
        chk("Level", 32'(Level), 32'(model_q.size()));
        chk("Empty", 32'(Empty), 32'(model_q.size() == 0));
        chk("Full",  32'(Full),  32'(model_q.size() == int'(DEPTH)));
        chk("InRdy", 32'(InRdy), 32'(model_q.size() != int'(DEPTH)));
`ifdef PACKER_FEEDER_STALL_CNT_EN
        chk("StallCnt", 32'(StallCnt), 32'(m_stall));
`endif
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        @(negedge clk);
        InVld  = v;
        InDat  = d;
        ReqDat = r;
        Flush  = f;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Fill to DEPTH with no requests, then drain at one word per clock.
        for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        // Requests against an empty FIFO, then a late word.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        // Full with simultaneous push and pop: only the pop happens, push lands next cycle.
        for (int i = 0; i < 16; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'hE1, 1'b1, 1'b0);
        step(1'b1, 8'hE2, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 17; i++) step(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        // Streaming at shallow occupancy across several pointer wraps.
        step(1'b1, 8'h40, 1'b0, 1'b0);
        step(1'b1, 8'h41, 1'b0, 1'b0);
        for (int i = 2; i < 40; i++) step(1'b1, DW'(8'h40 + i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        // Flush at Level=5 while requesting; the next push is the next delivery.
        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h90 + i), 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 4; i++) step(1'b1, DW'(8'h20 + i), 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        InVld  = 1'b0;
        ReqDat = 1'b0;
        #1;
        chk("rst_ValDat", 32'(ValDat), 32'(0));
        chk("rst_Dat",    32'(Dat),    32'(0));
        chk("rst_Level",  32'(Level),  32'(0));
        chk("rst_Empty",  32'(Empty),  32'(1));
        chk("rst_Full",   32'(Full),   32'(0));
        chk("rst_InRdy",  32'(InRdy),  32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        // Randomised traffic with bursty request/valid phases and occasional flushes.
        for (int blk = 0; blk < 30; blk++) begin
            int unsigned pv = $urandom_range(1, 4);
            int unsigned pr = $urandom_range(1, 4);
            for (int i = 0; i < 100; i++) begin
                step(($urandom_range(1, 4) <= pv), DW'($urandom), ($urandom_range(1, 4) <= pr),
                     ($urandom_range(0, 99) == 0));
            end
        end
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
        idle(2);

`ifdef PACKER_FEEDER_STALL_CNT_EN
        // Drive the stall counter into saturation, then clear it with a flush.
        for (int i = 0; i < 65540; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        idle(2);
`endif

        @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
